weight_fetch_scheduler: RTL
===========================

# weight_fetch_scheduler

Double-buffered weight-fetch scheduler between the weight memory (`rom_memory2`) and the `systolic_array` weight inputs. It sequences one weight word per round from a base address, and prefetches the next round's word into a shadow bank while the array computes. On the SA controller's swap handshake it commits that word to the active bank. It replaces the single `f_weight_array_reg` load path and owns round counting for weights.

## Interface
Parameters:
- `N_ROWS_ARRAY`, 9, number of array rows (weights per word)
- `F_WIDTH`, 8, weight width in bits
- `SIG_ADDRS_WIDTH`, 10, weight memory address width
- `COUNTER_ROUND_WIDTH`, 3, round counter width

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rd_weight_rst`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  one-cycle pulse that begins a layer; sampled only in IDLE
- `base_addr_i`  in  SIG_ADDRS_WIDTH  first weight address; latched on accepted `start_i`
- `n_round_weight_i`  in  COUNTER_ROUND_WIDTH  number of rounds; latched on accepted `start_i`
- `swap_i`  in  1  level request from the SA controller to commit the next round; held until `swap_ack_o`
- `swap_ack_o`  out  1  commit occurs at the closing edge of this cycle
- `mem_rd_o`  out  1  read strobe to the weight memory
- `mem_addr_o`  out  SIG_ADDRS_WIDTH  weight memory read address
- `mem_data_i`  in  N_ROWS_ARRAY*F_WIDTH  memory data, valid the cycle after `mem_rd_o`
- `weight_o`  out  N_ROWS_ARRAY*F_WIDTH  active bank; row r occupies bits `[(r+1)*F_WIDTH-1 : r*F_WIDTH]`
- `shadow_valid_o`  out  1  shadow bank holds an uncommitted word
- `round_o`  out  COUNTER_ROUND_WIDTH  count of commits in the current layer
- `busy_o`  out  1  state is not IDLE
- `done_o`  out  1  one-cycle pulse when the layer completes

## Operation
- FSM states: IDLE, FETCH, CAPTURE, READY, DONE.
- IDLE:
  - `start_i` with `n_round_weight_i` != 0: latch the inputs, clear `fetch_idx` and `round_o`, go to FETCH.
  - `start_i` with `n_round_weight_i` == 0: go to DONE with no memory access.
- FETCH:
  - `mem_rd_o` = 1 and `mem_addr_o` = `base_addr + fetch_idx`, modulo 2^SIG_ADDRS_WIDTH (wraps).
  - Increment `fetch_idx`, then go to CAPTURE.
- CAPTURE: shadow bank <= `mem_data_i`; set `shadow_valid`; go to READY.
- READY: `swap_ack_o` = `swap_i`. On ack:
  - active <= shadow, clear `shadow_valid`, increment `round_o`.
  - If `fetch_idx` < `n_rounds`, go to FETCH; otherwise go to DONE.
- DONE: `done_o` = 1 for one cycle, then IDLE. `weight_o` holds the last committed word until the next commit or reset.
- `swap_i` outside READY is not acknowledged. The requester stalls until a word is ready.
- `start_i` while `busy_o` is ignored.
- Reset values: all outputs 0, both banks 0, `round_o` = 0, state IDLE.
- Reset mid-layer aborts immediately. No `done_o` pulse is produced.

## Timing
- `start_i` at cycle t: FETCH at t+1, CAPTURE at t+2, `shadow_valid_o` = 1 from t+3.
- Earliest ack is at t+3. `weight_o` updates at t+4.
- After an ack at cycle k, the next word is shadow-valid at k+3. The minimum swap period is 3 cycles.
- Last ack at cycle k: `done_o` = 1 at k+1, `busy_o` = 0 at k+2.
- `mem_addr_o` is 0 whenever `mem_rd_o` = 0.

## Configuration
- `SPARHIXCEL_WPREFETCH_EN` defined: double-buffered operation exactly as above.
- Not defined: single-buffer operation.
  - Flow is IDLE → READY, waiting for `swap_i` with no shadow word; the request triggers FETCH then CAPTURE.
  - `mem_data_i` is written directly to the active bank.
  - `swap_ack_o` is asserted in the CAPTURE cycle.
  - Latency is 2 cycles from `swap_i` to ack; the swap period is 3 cycles.
  - `shadow_valid_o` is tied to 0.

## Structure
- `sparhixcel_pkg` holds:
  - the FSM state enum `wfs_state_t`;
  - the shared constants `N_ROWS_ARRAY`, `F_WIDTH`, `SIG_ADDRS_WIDTH`, `COUNTER_ROUND_WIDTH`.
- Sub-module `weight_reg_bank` is a flat register with load enable and asynchronous clear. It is instantiated for the active bank and the shadow bank; the shadow instance is compiled out without the macro.

## Test plan
- Reset release, then `start_i` with base = 0x010, n = 3, `swap_i` held high → reads at 0x010, 0x011, 0x012; three acks 3 cycles apart; `round_o` steps 1→2→3; one `done_o` pulse.
- base = 0x3FF, n = 2 → reads at 0x3FF then 0x000.
- `swap_i` held low for 10 cycles in READY → no ack, `weight_o` unchanged, `shadow_valid_o` stays 1.
- `start_i` with n = 0 → `done_o` at t+1, `mem_rd_o` never asserted.
- `rd_weight_rst` pulsed during the second CAPTURE → `weight_o` = 0, `round_o` = 0, IDLE, no `done_o`.
- Without the macro: `swap_i` at cycle k → `mem_rd_o` at k+1, ack at k+2, `weight_o` = fetched word at k+3.

Source files
------------

// File: rtl/sparhixcel_pkg.sv
// Shared constants and FSM state type for the weight fetch scheduler.
package sparhixcel_pkg;

    localparam int N_ROWS_ARRAY        = 9;
    localparam int F_WIDTH             = 8;
    localparam int SIG_ADDRS_WIDTH     = 10;
    localparam int COUNTER_ROUND_WIDTH = 3;

    typedef enum logic [2:0] {
        WFS_IDLE,
        WFS_FETCH,
        WFS_CAPTURE,
        WFS_READY,
        WFS_DONE
    } wfs_state_t;

endpackage

// File: rtl/weight_reg_bank.sv
// Flat weight register with load enable and asynchronous clear.
module weight_reg_bank #(
    parameter int W = 72
) (
    input  logic         clk_i,
    input  logic         rd_weight_rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/weight_fetch_scheduler.sv
// Weight fetch scheduler; SPARHIXCEL_WPREFETCH_EN selects
// double-buffered prefetch, otherwise single-buffer fetch on demand.
module weight_fetch_scheduler #(
    parameter int N_ROWS_ARRAY        = sparhixcel_pkg::N_ROWS_ARRAY,
    parameter int F_WIDTH             = sparhixcel_pkg::F_WIDTH,
    parameter int SIG_ADDRS_WIDTH     = sparhixcel_pkg::SIG_ADDRS_WIDTH,
    parameter int COUNTER_ROUND_WIDTH = sparhixcel_pkg::COUNTER_ROUND_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rd_weight_rst,
    input  logic                              start_i,
    input  logic [SIG_ADDRS_WIDTH-1:0]        base_addr_i,
    input  logic [COUNTER_ROUND_WIDTH-1:0]    n_round_weight_i,
    input  logic                              swap_i,
    output logic                              swap_ack_o,
    output logic                              mem_rd_o,
    output logic [SIG_ADDRS_WIDTH-1:0]        mem_addr_o,
    input  logic [N_ROWS_ARRAY*F_WIDTH-1:0]   mem_data_i,
    output logic [N_ROWS_ARRAY*F_WIDTH-1:0]   weight_o,
    output logic                              shadow_valid_o,
    output logic [COUNTER_ROUND_WIDTH-1:0]    round_o,
    output logic                              busy_o,
    output logic                              done_o
);
    import sparhixcel_pkg::*;

    localparam int WW = N_ROWS_ARRAY * F_WIDTH;

    wfs_state_t state, state_nxt;

    logic [SIG_ADDRS_WIDTH-1:0]     base_q;
    logic [COUNTER_ROUND_WIDTH-1:0] n_q;
    logic [COUNTER_ROUND_WIDTH-1:0] fetch_idx;
    logic [COUNTER_ROUND_WIDTH-1:0] round_q;
    logic                           latch;
    logic                           commit;
    logic                           more;
    logic [WW-1:0]                  active_d;

    assign more = fetch_idx < n_q;

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            state <= WFS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        latch      = 1'b0;
        commit     = 1'b0;
        swap_ack_o = 1'b0;
        unique case (state)
            WFS_IDLE: begin
                if (start_i) begin
                    if (n_round_weight_i == '0) begin
                        state_nxt = WFS_DONE;
                    end else begin
                        latch = 1'b1;
`ifdef SPARHIXCEL_WPREFETCH_EN
                        state_nxt = WFS_FETCH;
`else
                        state_nxt = WFS_READY;
`endif
                    end
                end
            end
            WFS_FETCH: state_nxt = WFS_CAPTURE;
            WFS_CAPTURE: begin
`ifdef SPARHIXCEL_WPREFETCH_EN
                state_nxt = WFS_READY;
`else
                swap_ack_o = 1'b1;
                commit     = 1'b1;
                state_nxt  = more ? WFS_READY : WFS_DONE;
`endif
            end
            WFS_READY: begin
`ifdef SPARHIXCEL_WPREFETCH_EN
                if (swap_i) begin
                    swap_ack_o = 1'b1;
                    commit     = 1'b1;
                    state_nxt  = more ? WFS_FETCH : WFS_DONE;
                end
`else
                if (swap_i) begin
                    state_nxt = WFS_FETCH;
                end
`endif
            end
            WFS_DONE: state_nxt = WFS_IDLE;
            default:  state_nxt = WFS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            base_q    <= '0;
            n_q       <= '0;
            fetch_idx <= '0;
            round_q   <= '0;
        end else begin
            if (latch) begin
                base_q    <= base_addr_i;
                n_q       <= n_round_weight_i;
                fetch_idx <= '0;
                round_q   <= '0;
            end
            if (state == WFS_FETCH) begin
                fetch_idx <= fetch_idx + COUNTER_ROUND_WIDTH'(1);
            end
            if (commit) begin
                round_q <= round_q + COUNTER_ROUND_WIDTH'(1);
            end
        end
    end

    assign busy_o     = state != WFS_IDLE;
    assign done_o     = state == WFS_DONE;
    assign mem_rd_o   = state == WFS_FETCH;
    assign mem_addr_o = mem_rd_o
                      ? base_q + SIG_ADDRS_WIDTH'(fetch_idx)
                      : '0;
    assign round_o    = round_q;

`ifdef SPARHIXCEL_WPREFETCH_EN
    logic          shadow_valid_q;
    logic [WW-1:0] shadow_q;

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            shadow_valid_q <= 1'b0;
        end else if (state == WFS_CAPTURE) begin
            shadow_valid_q <= 1'b1;
        end else if (commit) begin
            shadow_valid_q <= 1'b0;
        end
    end

    weight_reg_bank #(.W(WW)) u_shadow (
        .clk_i         (clk_i),
        .rd_weight_rst (rd_weight_rst),
        .load          (state == WFS_CAPTURE),
        .d             (mem_data_i),
        .q             (shadow_q)
    );

    assign active_d       = shadow_q;
    assign shadow_valid_o = shadow_valid_q;
`else
    assign active_d       = mem_data_i;
    assign shadow_valid_o = 1'b0;
`endif

    weight_reg_bank #(.W(WW)) u_active (
        .clk_i         (clk_i),
        .rd_weight_rst (rd_weight_rst),
        .load          (commit),
        .d             (active_d),
        .q             (weight_o)
    );

endmodule
